nand_avalon_fifo: RTL and testbench
===================================

NAND_AVALON_FIFO -- requirements
Module: nand_avalon_fifo

Interface
REQ-001 Parameter NAND_DW, default 8, meaning NAND data path width; legal values 8 and 16.
REQ-002 Parameter FIFO_DEPTH, default 16, meaning entries per TX/RX FIFO; power of 2, 2..128.
REQ-003 clk  in  1  single clock; every register is updated on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 address  in  3  Avalon word address.
REQ-006 read  in  1  active-high read strobe.
REQ-007 write  in  1  active-high write strobe.
REQ-008 writedata  in  32  write data.
REQ-009 readdata  out  32  registered read data.
REQ-010 irq  out  1  level interrupt.
REQ-011 core_cmd  out  8  command byte to the NAND master core.
REQ-012 core_activate  out  1  one-cycle command start pulse.
REQ-013 core_busy  in  1  core busy flag.
REQ-014 core_tx_data  out  NAND_DW  TX FIFO head (first-word fall-through).
REQ-015 core_tx_valid  out  1  TX FIFO not empty.
REQ-016 core_tx_pop  in  1  core consumed the TX head.
REQ-017 core_rx_data  in  NAND_DW  word from the core.
REQ-018 core_rx_push  in  1  core_rx_data valid this cycle.

Function
REQ-019 Register map:
- 0 DATA: write pushes writedata[NAND_DW-1:0] into TX; read pops RX.
- 1 CMD: write issues a command.
- 2 STATUS: read-only bits, except write-1-to-clear on [12:8].
- 3 IRQ_EN: R/W, bits [1:0].
- 4 LEVELS: read-only; [7:0] tx_count, [23:16] rx_count.
- 5 CTRL: write-only; bit0 flushes TX, bit1 flushes RX.
- 6, 7: read 0; writes are ignored.
REQ-020 Read latency is exactly 1 cycle: readdata is updated on the edge after the read strobe and holds until the next read; unused bits read 0.
REQ-021 DATA read while RX is empty returns 0, performs no pop and sets rx_underflow.
REQ-022 DATA write while TX is full drops the word and sets tx_overflow; a same-cycle core_tx_pop frees the entry first, so the push succeeds and the count is unchanged.
REQ-023 core_rx_push while RX is full drops the word and sets rx_overflow; a same-cycle DATA read pop frees the entry first, so the push succeeds.
REQ-024 A CTRL flush empties the selected FIFO in one cycle and takes priority over a same-cycle push or pop on that FIFO; the overflow/underflow sticky bits are unaffected.
REQ-025 STATUS bit assignments:
- 0 core_busy
- 1 cmd_pending
- 2 tx_full
- 3 tx_empty
- 4 rx_full
- 5 rx_empty
- 8 tx_overflow
- 9 rx_underflow
- 10 rx_overflow
- 11 cmd_overrun
- 12 done
REQ-026 The command FSM has states IDLE, ISSUE, WAIT_ACK and RUN.
REQ-027 IDLE + CMD write: latch writedata[7:0] into core_cmd, go to ISSUE, set cmd_pending.
REQ-028 ISSUE asserts core_activate for exactly one cycle, then goes to WAIT_ACK.
REQ-029 WAIT_ACK: core_busy=1 -> RUN; otherwise a 3-bit counter expires after 4 cycles and the FSM goes to IDLE with done set.
REQ-030 RUN: core_busy=0 -> IDLE, set done, clear cmd_pending.
REQ-031 A CMD write in any state other than IDLE is rejected (core_cmd unchanged) and sets cmd_overrun.
REQ-032 irq = (done & IRQ_EN[0]) | ((tx_overflow|rx_underflow|rx_overflow|cmd_overrun) & IRQ_EN[1]), registered; it changes one cycle after its cause.
REQ-033 Counts are ceil(log2(FIFO_DEPTH))+1 bits wide, zero-extended into LEVELS; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-034 Simultaneous read and write strobes are both honoured.

Reset
REQ-035 While reset=1 on a clock edge:
- FSM goes to IDLE; both FIFOs empty; all sticky bits, IRQ_EN and cmd_pending cleared.
- readdata=0, irq=0, core_cmd=0, core_activate=0, core_tx_valid=0.
REQ-036 Reset in mid-command returns to IDLE on that edge without a further activate pulse.

Verification
REQ-037 Write CMD=0x90 with core_busy rising 2 cycles after activate and falling 10 cycles later -> exactly one activate pulse; core_cmd=0x90; STATUS bit12=1; irq=1 if IRQ_EN=1.
REQ-038 Write 17 DATA words with FIFO_DEPTH=16 and no pops -> LEVELS[7:0]=16; STATUS bit8=1; the core pops words 1..16 in order.
REQ-039 Read DATA with RX empty -> readdata=0; STATUS bit9=1; writing 0x200 to STATUS clears bit9.
REQ-040 CMD write during RUN -> no activate pulse; core_cmd unchanged; STATUS bit11=1; with IRQ_EN=2, irq=1.
REQ-041 RX full with core_rx_push and a DATA read in the same cycle -> rx_count stays 16; no rx_overflow.
REQ-042 core_busy stuck low after activate -> FSM returns to IDLE 4 cycles after WAIT_ACK entry with done=1.

Source files
------------

// File: rtl/nand_avalon_fifo.sv
// -----------------------------------------------------------------------------
// nand_avalon_fifo
//
// Avalon-MM slave that connects a CPU to a NAND master core. It contains a
// TX FIFO (CPU -> core), an RX FIFO (core -> CPU), sticky status and error
// bits, a level interrupt, and a small FSM that hands one command byte at a
// time to the core.
//
// Parameters
//   NAND_DW     NAND data path width (8 or 16)
//   FIFO_DEPTH  entries per FIFO (power of 2, 2..128)
//
// Ports
//   clk, reset                  single clock, synchronous active-high reset
//   address/read/write          Avalon word address and strobes
//   writedata/readdata          32-bit data; readdata is registered (1 cycle)
//   irq                         registered level interrupt
//   core_cmd/core_activate      command byte and one-cycle start pulse
//   core_busy                   core is executing a command
//   core_tx_data/valid/pop      first-word fall-through TX FIFO head
//   core_rx_data/push           words from the core into the RX FIFO
//
// Register map (word addresses)
//   0 DATA    wr: push TX            rd: pop RX (0 and rx_underflow if empty)
//   1 CMD     wr: issue command      rd: 0
//   2 STATUS  rd: status bits        wr: write-1-to-clear on [12:8]
//   3 IRQ_EN  rd/wr bits [1:0]
//   4 LEVELS  rd: [7:0] tx_count, [23:16] rx_count
//   5 CTRL    wr: bit0 flush TX, bit1 flush RX
//   6, 7      rd: 0, writes ignored
// -----------------------------------------------------------------------------
module nand_avalon_fifo #(
    parameter int NAND_DW    = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               read,
    input  logic               write,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic               irq,
    output logic [7:0]         core_cmd,
    output logic               core_activate,
    input  logic               core_busy,
    output logic [NAND_DW-1:0] core_tx_data,
    output logic               core_tx_valid,
    input  logic               core_tx_pop,
    input  logic [NAND_DW-1:0] core_rx_data,
    input  logic               core_rx_push
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_CMD    = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_IRQ_EN = 3'd3;
    localparam logic [2:0] A_LEVELS = 3'd4;
    localparam logic [2:0] A_CTRL   = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_RUN
    } state_e;

    // ---------------------------------------------------------------- state
    state_e              state_q,       state_d;
    logic [2:0]          wait_cnt_q,    wait_cnt_d;
    logic [7:0]          core_cmd_q,    core_cmd_d;
    logic                cmd_pending_q, cmd_pending_d;

    logic [AW-1:0]       tx_wr_ptr_q,   tx_wr_ptr_d;
    logic [AW-1:0]       tx_rd_ptr_q,   tx_rd_ptr_d;
    logic [CW-1:0]       tx_count_q,    tx_count_d;
    logic [AW-1:0]       rx_wr_ptr_q,   rx_wr_ptr_d;
    logic [AW-1:0]       rx_rd_ptr_q,   rx_rd_ptr_d;
    logic [CW-1:0]       rx_count_q,    rx_count_d;

    logic                tx_ovf_q,      tx_ovf_d;
    logic                rx_udf_q,      rx_udf_d;
    logic                rx_ovf_q,      rx_ovf_d;
    logic                cmd_ovr_q,     cmd_ovr_d;
    logic                done_q,        done_d;
    logic [1:0]          irq_en_q,      irq_en_d;
    logic [31:0]         readdata_q,    readdata_d;
    logic                irq_q,         irq_d;

    logic [NAND_DW-1:0]  tx_mem_q [FIFO_DEPTH];
    logic [NAND_DW-1:0]  rx_mem_q [FIFO_DEPTH];

    // ------------------------------------------------------ decode / FIFOs
    logic wr_data, wr_cmd, wr_status, wr_irq_en, wr_ctrl, rd_data;
    logic tx_flush, rx_flush;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic tx_drop, rx_drop, rx_udf_evt;
    logic done_set, cmd_ovr_set;
    logic [31:0] status_word, levels_word;
    logic unused_wdata;

    // Only the low bits of writedata matter for most registers.
    assign unused_wdata = ^writedata;

    always_comb begin
        wr_data   = write && (address == A_DATA);
        wr_cmd    = write && (address == A_CMD);
        wr_status = write && (address == A_STATUS);
        wr_irq_en = write && (address == A_IRQ_EN);
        wr_ctrl   = write && (address == A_CTRL);
        rd_data   = read  && (address == A_DATA);

        tx_flush  = wr_ctrl && writedata[0];
        rx_flush  = wr_ctrl && writedata[1];

        tx_full   = (tx_count_q == DEPTH_C);
        tx_empty  = (tx_count_q == '0);
        rx_full   = (rx_count_q == DEPTH_C);
        rx_empty  = (rx_count_q == '0);

        // A same-cycle pop frees the slot before the push is judged, so a
        // full FIFO that is also being drained still accepts the new word.
        // A flush overrides everything on its FIFO and raises no error bits.
        tx_pop     = core_tx_pop && !tx_empty && !tx_flush;
        tx_push    = wr_data && (!tx_full || tx_pop) && !tx_flush;
        tx_drop    = wr_data && !tx_push && !tx_flush;

        rx_pop     = rd_data && !rx_empty && !rx_flush;
        rx_push    = core_rx_push && (!rx_full || rx_pop) && !rx_flush;
        rx_drop    = core_rx_push && !rx_push && !rx_flush;
        rx_udf_evt = rd_data && rx_empty && !rx_flush;

        if (tx_flush) begin
            tx_wr_ptr_d = '0;
            tx_rd_ptr_d = '0;
            tx_count_d  = '0;
        end else begin
            tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + AW'(1) : tx_wr_ptr_q;
            tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + AW'(1) : tx_rd_ptr_q;
            tx_count_d  = tx_count_q + CW'(tx_push) - CW'(tx_pop);
        end

        if (rx_flush) begin
            rx_wr_ptr_d = '0;
            rx_rd_ptr_d = '0;
            rx_count_d  = '0;
        end else begin
            rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + AW'(1) : rx_wr_ptr_q;
            rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + AW'(1) : rx_rd_ptr_q;
            rx_count_d  = rx_count_q + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // -------------------------------------------------------- command FSM
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        core_cmd_d    = core_cmd_q;
        cmd_pending_d = cmd_pending_q;
        done_set      = 1'b0;
        cmd_ovr_set   = 1'b0;
        core_activate = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wr_cmd) begin
                    core_cmd_d    = writedata[7:0];
                    cmd_pending_d = 1'b1;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_activate = 1'b1;
                wait_cnt_d    = '0;
                state_d       = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // Give the core four cycles to raise busy; a core that never
                // acknowledges is treated as having finished instantly.
                if (core_busy) begin
                    state_d = S_RUN;
                end else if (wait_cnt_q == 3'd3) begin
                    state_d       = S_IDLE;
                    done_set      = 1'b1;
                    cmd_pending_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            S_RUN: begin
                if (!core_busy) begin
                    state_d       = S_IDLE;
                    done_set      = 1'b1;
                    cmd_pending_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_cmd && (state_q != S_IDLE)) begin
            cmd_ovr_set = 1'b1;
        end
    end

    // ------------------------------------------- status, registers, readback
    always_comb begin
        status_word     = '0;
        status_word[0]  = core_busy;
        status_word[1]  = cmd_pending_q;
        status_word[2]  = tx_full;
        status_word[3]  = tx_empty;
        status_word[4]  = rx_full;
        status_word[5]  = rx_empty;
        status_word[8]  = tx_ovf_q;
        status_word[9]  = rx_udf_q;
        status_word[10] = rx_ovf_q;
        status_word[11] = cmd_ovr_q;
        status_word[12] = done_q;

        levels_word           = '0;
        levels_word[CW-1:0]   = tx_count_q;
        levels_word[16 +: CW] = rx_count_q;

        // Sticky bits: a new event in the same cycle as a clear wins.
        tx_ovf_d  = tx_drop     | (tx_ovf_q  & ~(wr_status & writedata[8]));
        rx_udf_d  = rx_udf_evt  | (rx_udf_q  & ~(wr_status & writedata[9]));
        rx_ovf_d  = rx_drop     | (rx_ovf_q  & ~(wr_status & writedata[10]));
        cmd_ovr_d = cmd_ovr_set | (cmd_ovr_q & ~(wr_status & writedata[11]));
        done_d    = done_set    | (done_q    & ~(wr_status & writedata[12]));

        irq_en_d = wr_irq_en ? writedata[1:0] : irq_en_q;

        irq_d = (done_q & irq_en_q[0])
              | ((tx_ovf_q | rx_udf_q | rx_ovf_q | cmd_ovr_q) & irq_en_q[1]);

        readdata_d = readdata_q;
        if (read) begin
            case (address)
                A_DATA:   readdata_d = rx_empty ? 32'h0 : 32'(rx_mem_q[rx_rd_ptr_q]);
                A_STATUS: readdata_d = status_word;
                A_IRQ_EN: readdata_d = {30'h0, irq_en_q};
                A_LEVELS: readdata_d = levels_word;
                default:  readdata_d = 32'h0;
            endcase
        end
    end

    // ------------------------------------------------------------ registers
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its _d value from before the edge regardless of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            core_cmd_q    <= '0;
            cmd_pending_q <= 1'b0;
            tx_wr_ptr_q   <= '0;
            tx_rd_ptr_q   <= '0;
            tx_count_q    <= '0;
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_count_q    <= '0;
            tx_ovf_q      <= 1'b0;
            rx_udf_q      <= 1'b0;
            rx_ovf_q      <= 1'b0;
            cmd_ovr_q     <= 1'b0;
            done_q        <= 1'b0;
            irq_en_q      <= '0;
            readdata_q    <= '0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            core_cmd_q    <= core_cmd_d;
            cmd_pending_q <= cmd_pending_d;
            tx_wr_ptr_q   <= tx_wr_ptr_d;
            tx_rd_ptr_q   <= tx_rd_ptr_d;
            tx_count_q    <= tx_count_d;
            rx_wr_ptr_q   <= rx_wr_ptr_d;
            rx_rd_ptr_q   <= rx_rd_ptr_d;
            rx_count_q    <= rx_count_d;
            tx_ovf_q      <= tx_ovf_d;
            rx_udf_q      <= rx_udf_d;
            rx_ovf_q      <= rx_ovf_d;
            cmd_ovr_q     <= cmd_ovr_d;
            done_q        <= done_d;
            irq_en_q      <= irq_en_d;
            readdata_q    <= readdata_d;
            irq_q         <= irq_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the counts gate every
    // use of it, so stale contents are never observable and the arrays can
    // map onto plain RAM.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= writedata[NAND_DW-1:0];
        end
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= core_rx_data;
        end
    end

    assign readdata      = readdata_q;
    assign irq           = irq_q;
    assign core_cmd      = core_cmd_q;
    assign core_tx_data  = tx_mem_q[tx_rd_ptr_q];
    assign core_tx_valid = !tx_empty;

endmodule

// File: tb/tb_nand_avalon_fifo.sv
// -----------------------------------------------------------------------------
// tb_nand_avalon_fifo
//
// Directed self-checking bench for nand_avalon_fifo (NAND_DW=8,
// FIFO_DEPTH=16). Inputs change on the falling clock edge, outputs are
// sampled on the falling edge, and every expected value below is worked out
// by hand from the register map.
// -----------------------------------------------------------------------------
module tb_nand_avalon_fifo;

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_CMD    = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_IRQ_EN = 3'd3;
    localparam logic [2:0] A_LEVELS = 3'd4;
    localparam logic [2:0] A_CTRL   = 3'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [7:0]  core_cmd;
    logic        core_activate;
    logic        core_busy;
    logic [7:0]  core_tx_data;
    logic        core_tx_valid;
    logic        core_tx_pop;
    logic [7:0]  core_rx_data;
    logic        core_rx_push;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nand_avalon_fifo #(
        .NAND_DW    (8),
        .FIFO_DEPTH (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .irq           (irq),
        .core_cmd      (core_cmd),
        .core_activate (core_activate),
        .core_busy     (core_busy),
        .core_tx_data  (core_tx_data),
        .core_tx_valid (core_tx_valid),
        .core_tx_pop   (core_tx_pop),
        .core_rx_data  (core_rx_data),
        .core_rx_push  (core_rx_push)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read    = 1'b0;
        d       = readdata;
    endtask

    task automatic bus_rw(input logic [2:0] a, input logic [31:0] wd, output logic [31:0] rd);
        @(negedge clk);
        address   = a;
        writedata = wd;
        read      = 1'b1;
        write     = 1'b1;
        @(negedge clk);
        read      = 1'b0;
        write     = 1'b0;
        rd        = readdata;
    endtask

    task automatic rx_push(input logic [7:0] d);
        @(negedge clk);
        core_rx_data = d;
        core_rx_push = 1'b1;
        @(negedge clk);
        core_rx_push = 1'b0;
    endtask

    // Issues a command, then plays a per-cycle script relative to the
    // activate cycle (k=0): busy rise/fall, an optional second CMD write, and
    // a two-cycle STATUS read whose results land in mid and mid2.
    task automatic run_cmd(input logic [7:0] cmd, input int rise, input int fall,
                           input int ovr_k, input int rd_k, input int ncyc,
                           output int acts, output logic [31:0] mid,
                           output logic [31:0] mid2);
        acts = 0;
        mid  = '0;
        mid2 = '0;
        bus_write(A_CMD, {24'h0, cmd});
        for (int k = 0; k < ncyc; k++) begin
            if (k == rd_k + 1) mid  = readdata;
            if (k == rd_k + 2) mid2 = readdata;
            write = 1'b0;
            read  = 1'b0;
            if (core_activate) acts++;
            if (k == rise) core_busy = 1'b1;
            if (k == fall) core_busy = 1'b0;
            if (k == ovr_k) begin
                address   = A_CMD;
                writedata = 32'h33;
                write     = 1'b1;
            end
            if (k == rd_k || k == rd_k + 1) begin
                address = A_STATUS;
                read    = 1'b1;
            end
            @(negedge clk);
        end
        write = 1'b0;
        read  = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] mid;
        logic [31:0] mid2;
        int          acts;

        reset        = 1'b1;
        address      = '0;
        read         = 1'b0;
        write        = 1'b0;
        writedata    = '0;
        core_busy    = 1'b0;
        core_tx_pop  = 1'b0;
        core_rx_data = '0;
        core_rx_push = 1'b0;

        // ---------------------------------------------------------- reset
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_core_cmd", {24'h0, core_cmd}, 32'h0);
        check("rst_activate", {31'h0, core_activate}, 32'h0);
        check("rst_tx_valid", {31'h0, core_tx_valid}, 32'h0);
        reset = 1'b0;
        bus_read(A_STATUS, rd);
        check("rst_status", rd, 32'h28);

        // ------------------------------------- normal command with busy ack
        bus_write(A_IRQ_EN, 32'h1);
        run_cmd(8'h90, 2, 12, -1, 6, 20, acts, mid, mid2);
        check("cmd90_activates", acts, 32'd1);
        check("cmd90_status_run", mid, 32'h2B);
        check("cmd90_core_cmd", {24'h0, core_cmd}, 32'h90);
        check("cmd90_irq", {31'h0, irq}, 32'h1);
        bus_read(A_STATUS, rd);
        check("cmd90_status_done", rd, 32'h1028);
        bus_write(A_STATUS, 32'h1000);
        @(negedge clk);
        check("cmd90_irq_cleared", {31'h0, irq}, 32'h0);

        // ------------------------------------------- CMD write during RUN
        bus_write(A_IRQ_EN, 32'h2);
        run_cmd(8'h60, 1, 8, 3, 5, 14, acts, mid, mid2);
        check("ovr_activates", acts, 32'd1);
        check("ovr_status_run", mid, 32'h82B);
        check("ovr_core_cmd", {24'h0, core_cmd}, 32'h60);
        check("ovr_irq", {31'h0, irq}, 32'h1);
        bus_read(A_STATUS, rd);
        check("ovr_status_done", rd, 32'h1828);
        bus_write(A_STATUS, 32'h1800);
        @(negedge clk);
        check("ovr_irq_cleared", {31'h0, irq}, 32'h0);

        // ------------------------------------------ no acknowledge timeout
        run_cmd(8'hA5, -1, -1, -1, 4, 8, acts, mid, mid2);
        check("tmo_activates", acts, 32'd1);
        check("tmo_status_last_wait", mid, 32'h2A);
        check("tmo_status_idle", mid2, 32'h1028);
        check("tmo_core_cmd", {24'h0, core_cmd}, 32'hA5);
        check("tmo_irq_masked", {31'h0, irq}, 32'h0);
        bus_write(A_IRQ_EN, 32'h1);
        @(negedge clk);
        check("tmo_irq_enabled", {31'h0, irq}, 32'h1);
        bus_write(A_STATUS, 32'h1000);
        @(negedge clk);
        check("tmo_irq_cleared", {31'h0, irq}, 32'h0);

        // ---------------------------------------------- TX fill / overflow
        for (int i = 1; i <= 17; i++) bus_write(A_DATA, 32'(i));
        bus_read(A_LEVELS, rd);
        check("tx_levels_full", rd, 32'h10);
        bus_read(A_STATUS, rd);
        check("tx_status_ovf", rd, 32'h124);
        check("tx_valid_full", {31'h0, core_tx_valid}, 32'h1);
        @(negedge clk);
        core_tx_pop = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("tx_pop_%0d", i), {24'h0, core_tx_data}, 32'(i));
            @(negedge clk);
        end
        core_tx_pop = 1'b0;
        check("tx_valid_empty", {31'h0, core_tx_valid}, 32'h0);
        bus_read(A_LEVELS, rd);
        check("tx_levels_empty", rd, 32'h0);
        bus_write(A_STATUS, 32'h100);

        // full TX with push and pop in the same cycle
        for (int i = 0; i < 16; i++) bus_write(A_DATA, 32'hA0 + 32'(i));
        @(negedge clk);
        address     = A_DATA;
        writedata   = 32'hEE;
        write       = 1'b1;
        core_tx_pop = 1'b1;
        @(negedge clk);
        write       = 1'b0;
        core_tx_pop = 1'b0;
        bus_read(A_LEVELS, rd);
        check("tx_pushpop_levels", rd, 32'h10);
        bus_read(A_STATUS, rd);
        check("tx_pushpop_status", rd, 32'h24);
        check("tx_pushpop_head", {24'h0, core_tx_data}, 32'hA1);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_LEVELS, rd);
        check("tx_flush_levels", rd, 32'h0);
        check("tx_flush_valid", {31'h0, core_tx_valid}, 32'h0);

        // ------------------------------------------------- RX underflow
        bus_read(A_STATUS, rd);
        check("udf_status_before", rd, 32'h28);
        bus_read(A_DATA, rd);
        check("udf_readdata", rd, 32'h0);
        bus_read(A_STATUS, rd);
        check("udf_status_set", rd, 32'h228);
        bus_write(A_STATUS, 32'h200);
        bus_read(A_STATUS, rd);
        check("udf_status_cleared", rd, 32'h28);

        // ----------------------------------------------- RX fill / overflow
        for (int i = 0; i < 16; i++) rx_push(8'h40 + 8'(i));
        bus_read(A_LEVELS, rd);
        check("rx_levels_full", rd, 32'h0010_0000);
        @(negedge clk);
        core_rx_data = 8'h77;
        core_rx_push = 1'b1;
        address      = A_DATA;
        read         = 1'b1;
        @(negedge clk);
        core_rx_push = 1'b0;
        read         = 1'b0;
        check("rx_pushpop_readdata", readdata, 32'h40);
        bus_read(A_LEVELS, rd);
        check("rx_pushpop_levels", rd, 32'h0010_0000);
        bus_read(A_STATUS, rd);
        check("rx_pushpop_status", rd, 32'h18);
        rx_push(8'h88);
        bus_read(A_STATUS, rd);
        check("rx_ovf_status", rd, 32'h418);
        bus_rw(A_DATA, 32'h5A, rd);
        check("rw_data_readdata", rd, 32'h41);
        bus_read(A_LEVELS, rd);
        check("rw_data_levels", rd, 32'h000F_0001);
        bus_write(A_CTRL, 32'h3);
        bus_read(A_LEVELS, rd);
        check("flush_both_levels", rd, 32'h0);
        bus_read(A_STATUS, rd);
        check("flush_keeps_sticky", rd, 32'h428);
        bus_rw(A_STATUS, 32'h400, rd);
        check("rw_status_readdata", rd, 32'h428);
        bus_read(A_STATUS, rd);
        check("rw_status_cleared", rd, 32'h28);

        // ------------------------------------------ reset in mid-command
        bus_write(A_DATA, 32'h12);
        bus_write(A_CMD, 32'h11);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_readdata", readdata, 32'h0);
        check("midrst_core_cmd", {24'h0, core_cmd}, 32'h0);
        check("midrst_tx_valid", {31'h0, core_tx_valid}, 32'h0);
        acts = 0;
        repeat (6) begin
            if (core_activate) acts++;
            @(negedge clk);
        end
        check("midrst_activates", acts, 32'd0);
        bus_read(A_STATUS, rd);
        check("midrst_status", rd, 32'h28);
        bus_read(A_IRQ_EN, rd);
        check("midrst_irq_en", rd, 32'h0);
        bus_read(A_LEVELS, rd);
        check("midrst_levels", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
